// File: rtl/iterlzc.sv
// iterlzc: multi-cycle leading-zero / leading-sign counter that scans CHUNK bits per cycle
// and returns the count together with the left-normalised operand.
module iterlzc #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Start,
    input  logic [WIDTH-1:0]           Num,
    input  logic                       Mode,
    output logic                       Busy,
    output logic                       Done,
    output logic [$clog2(WIDTH+1)-1:0] ZeroCnt,
    output logic [WIDTH-1:0]           NormNum,
    output logic                       AllZero
);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = $clog2(NCH + 1);

    if (WIDTH < 1 || CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_params
        $error("iterlzc: CHUNK must be >= 1 and divide WIDTH");
    end

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state, nxt;
    logic [WIDTH-1:0] work, shadow;
    logic [CW-1:0]    cnt, clz, fin_cnt;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] top;
    logic             accept, finish;

    assign top     = work[WIDTH-1 -: CHUNK];
    assign fin_cnt = cnt + clz;
    assign accept  = Start && state != SCAN;
    assign finish  = state == SCAN && (top != '0 || idx == IW'(NCH - 1));
    assign Busy    = state == SCAN;
    assign Done    = state == DONE;

    // Lowest set bit is overwritten by higher ones, leaving the MSB-most position.
    always_comb begin
        clz = CW'(CHUNK);
        for (int i = 0; i < CHUNK; i++)
            if (top[i]) clz = CW'(CHUNK - 1 - i);
    end

    always_comb begin
        nxt = state;
        if (state == SCAN) nxt = finish ? DONE : SCAN;
        else               nxt = Start ? SCAN : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            work    <= '0;
            shadow  <= '0;
            cnt     <= '0;
            idx     <= '0;
            ZeroCnt <= '0;
            NormNum <= '0;
            AllZero <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                work   <= Num ^ {WIDTH{Mode & Num[WIDTH-1]}};
                shadow <= Num;
                cnt    <= '0;
                idx    <= '0;
            end else if (finish) begin
                ZeroCnt <= fin_cnt;
                NormNum <= shadow << fin_cnt;
                AllZero <= fin_cnt == CW'(WIDTH);
            end else if (state == SCAN) begin
                cnt  <= cnt + CW'(CHUNK);
                work <= work << CHUNK;
                idx  <= idx + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_iterlzc.sv
// tb_iterlzc: directed stimulus with a transaction-level reference model checked every cycle,
// plus literal expectations for counts, normalised values and Done timing.
module tb_iterlzc;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic [63:0] Num = '0;
    logic        Mode = 1'b0;
    logic        Busy, Done, AllZero;
    logic [6:0]  ZeroCnt;
    logic [63:0] NormNum;

    int compared = 0;
    int mismatched = 0;

    iterlzc #(.WIDTH(64), .CHUNK(8)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Num(Num), .Mode(Mode),
        .Busy(Busy), .Done(Done), .ZeroCnt(ZeroCnt), .NormNum(NormNum), .AllZero(AllZero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: count leading bits equal to the reference bit (0, or the sign in Mode 1).
    function automatic int ref_count(input logic [63:0] n, input logic m);
        logic r;
        int c;
        r = m ? n[63] : 1'b0;
        c = 0;
        for (int i = 63; i >= 0; i--) begin
            if (n[i] != r) break;
            c++;
        end
        return c;
    endfunction

    int          m_rem = 0;
    logic        m_done = 1'b0;
    logic        armed = 1'b0;
    int          pz = 0, hz = 0;
    logic [63:0] pn = '0, hn = '0;

    // Transaction model: on accept, Busy lasts (chunk holding the first differing bit)+1 cycles.
    always @(posedge clk) begin
        if (reset) begin
            armed = 1'b1;
            m_rem = 0;
            m_done = 1'b0;
            hz = 0;
            hn = '0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_done = 1'b1;
                hz = pz;
                hn = pn;
            end
        end else begin
            m_done = 1'b0;
            if (Start) begin
                pz = ref_count(Num, Mode);
                pn = Num << pz;
                m_rem = (pz >= 64 ? 7 : pz / 8) + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("busy", 64'(Busy), 64'(m_rem > 0));
            chk("done", 64'(Done), 64'(m_done));
            chk("zerocnt", 64'(ZeroCnt), 64'(hz));
            chk("normnum", NormNum, hn);
            chk("allzero", 64'(AllZero), 64'(hz == 64));
        end
    end

    // Start is driven in cycle 0; returns at the negedge of the Done cycle.
    task automatic op(input logic [63:0] n, input logic m, input int ez, input logic [63:0] en, input int ecyc);
        int cyc;
        Num = n;
        Mode = m;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        cyc = 1;
        while (!Done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_cycle", 64'(cyc), 64'(ecyc));
        chk("lit_zerocnt", 64'(ZeroCnt), 64'(ez));
        chk("lit_normnum", NormNum, en);
        chk("lit_allzero", 64'(AllZero), 64'(ez == 64));
    endtask

    initial begin
        int cyc;
        int dones;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_zerocnt", 64'(ZeroCnt), 64'd0);
        chk("rst_normnum", NormNum, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        op(64'h8000_0000_0000_0000, 1'b0, 0, 64'h8000_0000_0000_0000, 2);
        op(64'h0000_0000_0001_0000, 1'b0, 47, 64'h8000_0000_0000_0000, 7);
        op(64'h0, 1'b0, 64, 64'h0, 9);
        op(64'hFFFF_F800_0000_0001, 1'b1, 21, 64'h0000_0000_0020_0000, 4);
        op(64'h7FFF_0000_0000_0000, 1'b1, 1, 64'hFFFE_0000_0000_0000, 2);
        op(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64, 64'h0, 9);
        op(64'h0000_0000_0000_0080, 1'b0, 56, 64'h8000_0000_0000_0000, 9);
        @(negedge clk);

        Num = 64'h1;
        Mode = 1'b0;
        Start = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (!Done && cyc < 20) begin
            if (cyc == 3) begin
                Num = 64'hFF;
                Start = 1'b1;
            end else Start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk("seq_done_cycle", 64'(cyc), 64'd9);
        chk("seq_zerocnt", 64'(ZeroCnt), 64'd63);
        op(64'h00FF_0000_0000_0000, 1'b0, 8, 64'hFF00_0000_0000_0000, 3);
        @(negedge clk);

        Num = 64'h0;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rr_busy", 64'(Busy), 64'd0);
        chk("rr_zerocnt", 64'(ZeroCnt), 64'd0);
        chk("rr_normnum", NormNum, 64'd0);
        chk("rr_allzero", 64'(AllZero), 64'd0);
        dones = 0;
        repeat (12) begin
            if (Done) dones++;
            @(negedge clk);
        end
        chk("rr_no_done", 64'(dones), 64'd0);
        op(64'h8000_0000_0000_0000, 1'b0, 0, 64'h8000_0000_0000_0000, 2);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
